// File: rtl/aes_128_pkg.sv
// Shared AES-128 definitions: key-expansion FSM states, round constants and
// the S-box table that the core's SubBytes uses as well.
package aes_128_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_BEATS = 22;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_HI = 2'd1,
      WR_LO = 2'd2
   } key_exp_state_e;

   // Byte 0x00 sits in the top 8 bits, so byte b lives at bit offset (255-b)*8.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] aes_sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_128_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_128_sub_word
   import aes_128_pkg::*;
(
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      assign word_o[8*i +: 8] = aes_sbox(word_i[8*i +: 8]);
   end

endmodule

// File: rtl/aes_128_key_expand.sv
// AES-128 round-key expansion: streams the 11 round keys as 22 back-to-back
// 64-bit beats (hi half first) into the key RAM write port.
module aes_128_key_expand
   import aes_128_pkg::*;
#(
   parameter int NR = AES_NR
)(
   input  logic         clk,
   input  logic         kill,
   input  logic [127:0] key_in,
   input  logic         key_load,
   input  logic         keyram_wr_idle,
   output logic         en_wr,
   output logic [63:0]  key_round_wr,
   output logic         busy,
   output logic         done_pulse,
   output logic         load_collision_irq_pulse
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   key_exp_state_e state_q, state_d;
   logic [127:0]   rk_q, rk_d;
   logic [3:0]     rnd_q, rnd_d;
   logic           en_wr_q, en_wr_d;
   logic [63:0]    wr_data_q, wr_data_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           irq_q, irq_d;

   logic [31:0]    rot_s, sub_s, t_s;
   logic [31:0]    w0n_s, w1n_s, w2n_s, w3n_s;
   logic [127:0]   rk_next_s;

   // Next round key: one SubWord on the rotated last word, then the XOR ripple.
   assign rot_s = {rk_q[23:0], rk_q[31:24]};

   aes_128_sub_word u_sub_word (
      .word_i (rot_s),
      .word_o (sub_s)
   );

   assign t_s       = sub_s ^ {aes_rcon(rnd_q), 24'h000000};
   assign w0n_s     = rk_q[127:96] ^ t_s;
   assign w1n_s     = rk_q[95:64]  ^ w0n_s;
   assign w2n_s     = rk_q[63:32]  ^ w1n_s;
   assign w3n_s     = rk_q[31:0]   ^ w2n_s;
   assign rk_next_s = {w0n_s, w1n_s, w2n_s, w3n_s};

   // Next-state, working-key and pulse decode.
   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      rnd_d   = rnd_q;
      done_d  = 1'b0;
      irq_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (key_load && keyram_wr_idle) begin
               rk_d    = key_in;
               rnd_d   = 4'd0;
               state_d = WR_HI;
            end else begin
               irq_d   = key_load;
            end
         end
         WR_HI: begin
            irq_d   = key_load;
            state_d = WR_LO;
         end
         WR_LO: begin
            irq_d = key_load;
            if (rnd_q == LAST_RND) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               rk_d    = rk_next_s;
               rnd_d   = rnd_q + 4'd1;
               state_d = WR_HI;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Write-port values are computed from the upcoming state so outputs stay registered.
   always_comb begin
      en_wr_d = (state_d != IDLE);
      busy_d  = (state_d != IDLE);
      case (state_d)
         WR_HI:   wr_data_d = rk_d[127:64];
         WR_LO:   wr_data_d = rk_d[63:0];
         default: wr_data_d = 64'h0;
      endcase
   end

   // State, working key, counter and output registers.
   always_ff @(posedge clk or posedge kill) begin
      if (kill) begin
         state_q   <= IDLE;
         rk_q      <= 128'h0;
         rnd_q     <= 4'd0;
         en_wr_q   <= 1'b0;
         wr_data_q <= 64'h0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rk_q      <= rk_d;
         rnd_q     <= rnd_d;
         en_wr_q   <= en_wr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         irq_q     <= irq_d;
      end
   end

   assign en_wr                    = en_wr_q;
   assign key_round_wr             = wr_data_q;
   assign busy                     = busy_q;
   assign done_pulse               = done_q;
   assign load_collision_irq_pulse = irq_q;

endmodule
